// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: one outstanding imem read, 1-entry skid,
// redirect/stop handling with stale-response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] branch_pc,
  input  logic        branch_jump_signal,
  input  logic        take_or_not,
  input  logic        stop,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [63:0] imem_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr0,
  output logic [31:0] instr1,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        drop;
  logic        drop_nxt;
  logic        skid_valid;
  logic [95:0] skid;
  logic [95:0] pair_in;
  logic        redirect;
  logic        active;
  logic        cap;
  logic        free;

  assign redirect = branch_jump_signal & take_or_not;
  assign active   = (state != S_HALT);
  assign pair_in  = {pc, imem_data};
  assign free     = !fetch_valid | !stall;
  assign halted   = (state == S_HALT);

  // A response is only kept if nothing kills the fetch stream this cycle
  assign cap = (state == S_WAIT) & imem_valid & !drop
             & !redirect & !stop;

  assign imem_req = (state == S_REQ) & !skid_valid & !drop
                  & !redirect & !stop & !reset;

  assign imem_addr = imem_req ? {pc[31:2], 2'b00} : 32'h0;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    if (drop & imem_valid) drop_nxt = 1'b0;
    unique case (state)
      S_REQ: begin
        if (imem_req) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          state_nxt = S_REQ;
          pc_nxt    = pc + 32'd8;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: state_nxt = S_REQ;
    endcase
    if (active & (stop | redirect)) begin
      // A read still in flight must be swallowed when it returns
      drop_nxt = ((state == S_WAIT) | drop) & !imem_valid;
      if (stop) begin
        state_nxt = S_HALT;
        pc_nxt    = pc;
      end else begin
        state_nxt = S_REQ;
        pc_nxt    = branch_pc & 32'hFFFF_FFFC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= (state == S_WAIT) & !imem_valid;
      fetch_valid <= 1'b0;
      skid_valid  <= 1'b0;
      skid        <= '0;
      flush       <= 1'b0;
      pc_out      <= '0;
      instr0      <= '0;
      instr1      <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      flush <= active & (stop | redirect);
      if (!active) begin
        fetch_valid <= fetch_valid;
      end else if (stop | redirect) begin
        fetch_valid <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (free) begin
        if (skid_valid) begin
          {pc_out, instr0, instr1} <= skid;
          fetch_valid <= 1'b1;
          skid_valid  <= cap;
          if (cap) skid <= pair_in;
        end else if (cap) begin
          {pc_out, instr0, instr1} <= pair_in;
          fetch_valid <= 1'b1;
        end else begin
          fetch_valid <= 1'b0;
        end
      end else if (cap) begin
        skid       <= pair_in;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, stream-level reference model,
// directed scenarios plus a randomized stall/branch run.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] branch_pc;
  logic        branch_jump_signal;
  logic        take_or_not;
  logic        stop;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [63:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic        fetch_valid;
  logic        flush;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .branch_pc(branch_pc),
    .branch_jump_signal(branch_jump_signal),
    .take_or_not(take_or_not),
    .stop(stop),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_data(imem_data),
    .pc_out(pc_out),
    .instr0(instr0),
    .instr1(instr1),
    .fetch_valid(fetch_valid),
    .flush(flush),
    .halted(halted)
  );

  int total = 0;
  int bad = 0;
  int lat = 1;
  int flushes = 0;
  logic [31:0] seen[$];
  logic [31:0] reqs[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[31:16] ^ a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [31:0] q[$],
                       input int idx, input logic [31:0] exp);
    logic [31:0] v;
    v = (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    chk(nm, {32'h0, v}, {32'h0, exp});
  endtask

  // Memory: answers each request after lat cycles with the pair at addr
  initial begin
    logic [31:0] paddr;
    int cnt;
    cnt = 0;
    paddr = 0;
    imem_valid = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        chk("one_outstanding", cnt, 0);
        cnt = lat;
        paddr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_data = {mw(paddr), mw(paddr + 32'd4)};
        end
      end
    end
  end

  // Reference model: in-order pair stream and sequential request addresses
  initial begin
    logic [31:0] ep, rp, hp;
    bit ef, eh, f0, hold, rprev;
    ep = RPC; rp = RPC; hp = 0;
    ef = 0; eh = 0; f0 = 1; hold = 0; rprev = 1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("flush", flush, ef);
      chk("halted", halted, eh);
      if (rprev) begin
        chk("rst_pc_out", pc_out, 0);
        chk("rst_instr0", instr0, 0);
        chk("rst_instr1", instr1, 0);
      end
      if (reset) begin
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
      end
      if (f0) chk("fv_cleared", fetch_valid, 0);
      if (eh) begin
        chk("halt_req", imem_req, 0);
        chk("halt_fv", fetch_valid, 0);
      end
      if (hold) begin
        chk("hold_fv", fetch_valid, 1);
        chk("hold_pc", pc_out, hp);
      end
      if (fetch_valid) begin
        chk("pc_out", pc_out, ep);
        chk("instr0", instr0, mw(ep));
        chk("instr1", instr1, mw(ep + 32'd4));
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, rp);
        reqs.push_back(imem_addr);
      end
      if (flush) flushes++;
      ef = 0; f0 = 0; hold = 0; rprev = 0;
      if (reset) begin
        ep = RPC; rp = RPC; eh = 0; f0 = 1; rprev = 1;
      end else if (!eh) begin
        if (stop) begin
          eh = 1; ef = 1; f0 = 1;
        end else if (branch_jump_signal && take_or_not) begin
          ep = branch_pc & 32'hFFFF_FFFC;
          rp = ep; ef = 1; f0 = 1;
        end else begin
          if (fetch_valid && !stall) begin
            seen.push_back(pc_out);
            ep = ep + 32'd8;
          end
          if (fetch_valid && stall) begin
            hold = 1; hp = pc_out;
          end
          if (imem_req) rp = rp + 32'd8;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
    seen.delete();
    reqs.delete();
    flushes = 0;
  endtask

  task automatic wait_req(input logic [31:0] a, input bit any);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (imem_req && (any || imem_addr == a)) ok = 1;
    end
    if (!ok) chk("wait_req_timeout", 1, 0);
  endtask

  task automatic pulse_branch(input logic [31:0] t);
    branch_jump_signal = 1'b1;
    take_or_not = 1'b1;
    branch_pc = t;
    cyc(1);
    branch_jump_signal = 1'b0;
    take_or_not = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    branch_pc = '0;
    branch_jump_signal = 1'b0;
    take_or_not = 1'b0;
    stop = 1'b0;
    stall = 1'b0;

    // Sequential fetch, 1-cycle memory
    lat = 1;
    do_reset(2);
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    cyc(8);
    chk_q("seq_req1", reqs, 1, 32'h8);
    chk_q("seq_req2", reqs, 2, 32'h10);
    chk_q("seq_pc0", seen, 0, 32'h0);
    chk_q("seq_pc1", seen, 1, 32'h8);
    chk_q("seq_pc2", seen, 2, 32'h10);

    // Stall with pair 8 on outputs; pair 16 parks in the skid
    do_reset(2);
    wait_req(32'h8, 0);
    cyc(1);
    stall = 1'b1;
    cyc(1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_fv", fetch_valid, 1);
      cyc(1);
    end
    chk("stall_no_req", reqs.size(), 3);
    stall = 1'b0;
    @(negedge clk);
    chk("release_pc", pc_out, 32'h8);
    cyc(1);
    @(negedge clk);
    chk("skid_pc", pc_out, 32'h10);
    chk("skid_fv", fetch_valid, 1);
    cyc(1);

    // Taken branch while a read is in flight
    lat = 3;
    do_reset(2);
    wait_req(32'h0, 0);
    cyc(1);
    seen.delete();
    reqs.delete();
    flushes = 0;
    pulse_branch(32'h100);
    @(negedge clk);
    chk("br_flush", flush, 1);
    cyc(20);
    chk("br_flush_cnt", flushes, 1);
    chk_q("br_req0", reqs, 0, 32'h100);
    chk_q("br_pc0", seen, 0, 32'h100);
    chk_q("br_pc1", seen, 1, 32'h108);

    // Redirect in the same cycle the response lands
    lat = 2;
    do_reset(2);
    wait_req(32'h0, 0);
    cyc(2);
    seen.delete();
    pulse_branch(32'h203);
    cyc(12);
    chk_q("brv_pc0", seen, 0, 32'h200);

    // Not-taken branch leaves the stream alone
    lat = 1;
    do_reset(2);
    cyc(3);
    branch_jump_signal = 1'b1;
    take_or_not = 1'b0;
    branch_pc = 32'h500;
    cyc(6);
    branch_jump_signal = 1'b0;
    cyc(4);
    chk("nt_flush_cnt", flushes, 0);
    chk_q("nt_pc2", seen, 2, 32'h10);
    chk_q("nt_pc3", seen, 3, 32'h18);

    // Stop wins over a simultaneous taken branch
    lat = 2;
    do_reset(2);
    cyc(5);
    stop = 1'b1;
    pulse_branch(32'h300);
    stop = 1'b0;
    reqs.delete();
    @(negedge clk);
    chk("stop_halted", halted, 1);
    chk("stop_fv", fetch_valid, 0);
    chk("stop_flush", flush, 1);
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom);
      branch_jump_signal = 1'($urandom);
      take_or_not = 1'($urandom);
      branch_pc = $urandom;
      cyc(1);
    end
    stall = 1'b0;
    branch_jump_signal = 1'b0;
    take_or_not = 1'b0;
    chk("halt_no_req", reqs.size(), 0);
    chk("halt_hold", halted, 1);
    do_reset(2);
    cyc(8);
    chk_q("post_halt_pc0", seen, 0, 32'h0);
    chk_q("post_halt_pc1", seen, 1, 32'h8);

    // Address wrap past the top of memory
    lat = 1;
    do_reset(2);
    cyc(3);
    pulse_branch(32'hFFFF_FFF8);
    seen.delete();
    cyc(12);
    chk_q("wrap_pc0", seen, 0, 32'hFFFF_FFF8);
    chk_q("wrap_pc1", seen, 1, 32'h0);
    chk_q("wrap_pc2", seen, 2, 32'h8);

    // Reset while a read is outstanding
    lat = 4;
    do_reset(2);
    wait_req(32'h0, 0);
    cyc(1);
    do_reset(1);
    cyc(20);
    chk_q("rstmid_req0", reqs, 0, 32'h0);
    chk_q("rstmid_pc0", seen, 0, 32'h0);
    chk_q("rstmid_pc1", seen, 1, 32'h8);

    // Randomized stalls, latencies and branches
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      lat = 1 + int'($urandom % 3);
      stall = ($urandom % 10) < 3;
      branch_jump_signal = ($urandom % 20) == 0;
      take_or_not = 1'($urandom);
      branch_pc = $urandom;
      cyc(1);
    end
    stall = 1'b0;
    branch_jump_signal = 1'b0;
    take_or_not = 1'b0;
    cyc(4);
    chk("rand_progress", seen.size() > 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
